// File: rtl/ps2_scancode_decoder_pkg.sv
// Shared constants, types and helpers for the PS/2 set-2 scancode decoder.
package ps2_scancode_decoder_pkg;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;

    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    localparam int RD_VLD_BIT = 31;
    localparam int RD_OVF_BIT = 30;
    localparam int EVT_W      = 11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_PAUSE   = 3'd4
    } state_e;

    typedef struct packed {
        logic       pause;
        logic       brk;
        logic       ext;
        logic [7:0] code;
    } evt_t;

    // Keyboard responses (ACK, BAT pass, echo, resend, errors) never become key events.
    function automatic logic is_filtered(input logic [7:0] c);
        return (c == 8'hFA) || (c == 8'hAA) || (c == 8'hEE) || (c == 8'hFE) ||
               (c == 8'hFC) || (c == 8'h00) || (c == 8'hFF);
    endfunction

endpackage

// File: rtl/ps2_scancode_decoder_if.sv
// Byte-in / event-read bus between the PS/2 host, the decoder and the CPU.
interface ps2_scancode_decoder_if;
    logic        scan_vld;
    logic [7:0]  scan_code;
    logic        rd_en;
    logic [31:0] rd_dat;
    logic        irq;

    modport master (output scan_vld, output scan_code, output rd_en,
                    input  rd_dat,   input  irq);
    modport slave  (input  scan_vld, input  scan_code, input  rd_en,
                    output rd_dat,   output irq);
endinterface

// File: rtl/ps2_scancode_decoder_evt_fifo.sv
// Synchronous show-ahead event FIFO with full/empty/count.
// Latency: write visible at head one cycle after push.
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
module ps2_evt_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 11
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [W-1:0]               i_dat,
    output logic [W-1:0]               o_dat,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_count   = r_count;
    assign o_dat     = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_dat;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
        end
    end
endmodule

// File: rtl/ps2_scancode_decoder.sv
// Collapses PS/2 set-2 byte sequences into key events and queues them for a CPU read port.
// Latency: event at head and irq high the cycle after the completing byte.
// Backpressure: none upstream; full FIFO drops new events and sets sticky ovf.
module ps2_scancode_decoder
    import ps2_scancode_decoder_pkg::*;
#(
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    ps2_scancode_decoder_if.slave   io_bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_e        r_state, w_state_nxt;
    logic [2:0]    r_skip, w_skip_nxt;
    logic [TW-1:0] r_tmo, w_tmo_nxt;
    logic          r_ovf;
    logic          w_push;
    evt_t          w_evt;
    evt_t          w_head;
    logic          w_full, w_empty, w_pop, w_drop;
    logic [AW:0]   w_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_skip  <= '0;
            r_tmo   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_skip  <= w_skip_nxt;
            r_tmo   <= w_tmo_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_skip_nxt     = r_skip;
        w_tmo_nxt      = '0;
        w_push         = 1'b0;
        w_evt          = '0;
        w_evt.code     = io_bus.scan_code;
        if (io_bus.scan_vld) begin
            case (r_state)
                ST_IDLE: begin
                    if (io_bus.scan_code == PS2_EXT) begin
                        w_state_nxt = ST_EXT;
                    end else if (io_bus.scan_code == PS2_BRK) begin
                        w_state_nxt = ST_BRK;
                    end else if (io_bus.scan_code == PS2_PAUSE) begin
                        w_state_nxt = ST_PAUSE;
                        w_skip_nxt  = PAUSE_SKIP;
                    end else begin
                        w_push = ~is_filtered(io_bus.scan_code);
                    end
                end
                ST_EXT: begin
                    if (io_bus.scan_code == PS2_BRK) begin
                        w_state_nxt = ST_EXT_BRK;
                    end else if (io_bus.scan_code != PS2_EXT) begin
                        w_push      = 1'b1;
                        w_evt.ext   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    if (io_bus.scan_code != PS2_BRK) begin
                        w_push      = 1'b1;
                        w_evt.brk   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_EXT_BRK: begin
                    w_push      = 1'b1;
                    w_evt.brk   = 1'b1;
                    w_evt.ext   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
                ST_PAUSE: begin
                    // The pause sequence carries no key info; count bytes and emit one event.
                    w_skip_nxt = r_skip - 3'd1;
                    if (r_skip == 3'd1) begin
                        w_push      = 1'b1;
                        w_evt.pause = 1'b1;
                        w_evt.code  = PS2_PAUSE;
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end else if (r_state != ST_IDLE) begin
            if (r_tmo == TW'(TIMEOUT_CYCLES - 1)) begin
                w_state_nxt = ST_IDLE;
            end else begin
                w_tmo_nxt = r_tmo + TW'(1);
            end
        end
    end

    assign w_pop  = io_bus.rd_en & ~w_empty;
    assign w_drop = w_push & w_full & ~w_pop;

    ps2_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (EVT_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_pop   (io_bus.rd_en),
        .i_dat   (w_evt),
        .o_dat   (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // A drop in the same cycle as a read must still be reported.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (io_bus.rd_en) begin
            r_ovf <= 1'b0;
        end
    end

    always_comb begin
        io_bus.rd_dat             = '0;
        io_bus.rd_dat[RD_VLD_BIT] = ~w_empty;
        io_bus.rd_dat[RD_OVF_BIT] = r_ovf;
        if (!w_empty) begin
            io_bus.rd_dat[EVT_W-1:0] = w_head;
        end
    end

    assign io_bus.irq = (w_count != '0);
endmodule
